// File: rtl/axis_window_pkg.sv
// Shared definitions for the axis_window run controller: sequencer states and widths.
package axis_window_pkg;

  localparam int unsigned CFG_WIDTH      = 8;
  localparam int unsigned DEF_CNTR_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_GAP,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/axis_window_seq_timer.sv
// Loadable down-counter that stops at zero; used for both the flush hold and the
// inter-window dead time.
module axis_window_seq_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/axis_window_sequencer.sv
// Run controller for axis_window: gates input valid, counts windows, inserts dead
// time between windows and flushes the window via a local reset.
module axis_window_sequencer
  import axis_window_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH = DEF_CNTR_WIDTH,
  parameter int unsigned FLUSH_LEN  = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CFG_WIDTH-1:0]  cfg_len,
  input  logic [CNTR_WIDTH-1:0] cfg_count,
  input  logic [CNTR_WIDTH-1:0] cfg_gap,
  input  logic                  s_axis_tvalid,
  input  logic                  win_tvalid,
  output logic                  gate_tvalid,
  output logic [CFG_WIDTH-1:0]  win_cfg,
  output logic                  win_aresetn,
  output logic [CNTR_WIDTH-1:0] win_cntr,
  output logic                  busy,
  output logic                  done
);

  // Timer is loaded with (length - 1) so its zero flag marks the last cycle.
  localparam logic [CNTR_WIDTH-1:0] FLUSH_LOAD = CNTR_WIDTH'(FLUSH_LEN - 1);

  seq_state_t             r_state;
  seq_state_t             r_after_flush;
  logic                   r_gate;
  logic [CFG_WIDTH-1:0]   r_win_cfg;
  logic                   r_win_aresetn;
  logic [CNTR_WIDTH-1:0]  r_win_cntr;
  logic [CNTR_WIDTH-1:0]  r_count;
  logic [CNTR_WIDTH-1:0]  r_gap;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_start_ok;
  logic                   w_abort_ok;
  logic                   w_win_last;
  logic [CNTR_WIDTH-1:0]  w_cntr_inc;
  logic                   w_tmr_load;
  logic [CNTR_WIDTH-1:0]  w_tmr_val;
  logic                   w_tmr_zero;

  assign w_start_ok = (r_state == S_IDLE) && start && !abort && (cfg_count != '0);
  assign w_abort_ok = abort && ((r_state == S_FLUSH) || (r_state == S_RUN) || (r_state == S_GAP));
  assign w_cntr_inc = r_win_cntr + CNTR_WIDTH'(1);
  assign w_win_last = (w_cntr_inc == r_count);

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = FLUSH_LOAD;
    if (w_start_ok || w_abort_ok) begin
      w_tmr_load = 1'b1;
    end else if ((r_state == S_RUN) && win_tvalid && !w_win_last && (r_gap != '0)) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = r_gap - CNTR_WIDTH'(1);
    end
  end

  axis_window_seq_timer #(
    .WIDTH (CNTR_WIDTH)
  ) u_timer (
    .i_clk      (aclk),
    .i_rst_n    (aresetn),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_after_flush <= S_IDLE;
      r_gate        <= 1'b0;
      r_win_cfg     <= '0;
      r_win_aresetn <= 1'b1;
      r_win_cntr    <= '0;
      r_count       <= '0;
      r_gap         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort_ok) begin
        // Abort from any busy state restarts the flush and then parks in IDLE.
        r_state       <= S_FLUSH;
        r_after_flush <= S_IDLE;
        r_gate        <= 1'b0;
        r_win_aresetn <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_start_ok) begin
              r_win_cfg     <= cfg_len;
              r_count       <= cfg_count;
              r_gap         <= cfg_gap;
              r_win_cntr    <= '0;
              r_state       <= S_FLUSH;
              r_after_flush <= S_RUN;
              r_win_aresetn <= 1'b0;
              r_busy        <= 1'b1;
            end
          end
          S_FLUSH: begin
            if (w_tmr_zero) begin
              r_win_aresetn <= 1'b1;
              r_state       <= r_after_flush;
              if (r_after_flush == S_RUN) r_gate <= 1'b1;
              else                        r_busy <= 1'b0;
            end
          end
          S_RUN: begin
            if (win_tvalid) begin
              r_win_cntr <= w_cntr_inc;
              if (w_win_last) begin
                r_state <= S_DONE;
                r_gate  <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if (r_gap != '0) begin
                r_state <= S_GAP;
                r_gate  <= 1'b0;
              end
            end
          end
          S_GAP: begin
            if (w_tmr_zero) begin
              r_state <= S_RUN;
              r_gate  <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign gate_tvalid = s_axis_tvalid & r_gate;
  assign win_cfg     = r_win_cfg;
  assign win_aresetn = r_win_aresetn;
  assign win_cntr    = r_win_cntr;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_axis_window_sequencer.sv
// Directed and randomized bench for axis_window_sequencer against a remaining-cycles
// reference model, with a simple stand-in for the axis_window accumulator.
module tb_axis_window_sequencer;

  localparam int unsigned CW = 16;
  localparam int unsigned FL = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    cfg_len = '0;
  logic [CW-1:0] cfg_count = '0;
  logic [CW-1:0] cfg_gap = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          win_tvalid = 1'b0;
  logic          gate_tvalid;
  logic [7:0]    win_cfg;
  logic          win_aresetn;
  logic [CW-1:0] win_cntr;
  logic          busy;
  logic          done;

  always #5 aclk = ~aclk;

  axis_window_sequencer #(
    .CNTR_WIDTH (CW),
    .FLUSH_LEN  (FL)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .abort         (abort),
    .cfg_len       (cfg_len),
    .cfg_count     (cfg_count),
    .cfg_gap       (cfg_gap),
    .s_axis_tvalid (s_axis_tvalid),
    .win_tvalid    (win_tvalid),
    .gate_tvalid   (gate_tvalid),
    .win_cfg       (win_cfg),
    .win_aresetn   (win_aresetn),
    .win_cntr      (win_cntr),
    .busy          (busy),
    .done          (done)
  );

  // Reference model: remaining flush/gap cycles instead of named states.
  int m_flush_left, m_gap_left, m_cntr, m_count, m_gap, m_cfg;
  bit m_then_run, m_running, m_done;
  // Window stand-in: emits a win_tvalid pulse the cycle after the Nth gated sample.
  int wm_acc;
  bit wm_out, use_wm;

  int n_checks = 0;
  int n_errors = 0;
  int n_done_seen, n_gap_cyc, n_rst_low;

  function automatic bit m_busy();
    return (m_flush_left > 0) || m_running || (m_gap_left > 0);
  endfunction

  task automatic model_reset();
    m_flush_left = 0; m_gap_left = 0; m_cntr = 0; m_count = 0; m_gap = 0; m_cfg = 0;
    m_then_run = 0; m_running = 0; m_done = 0; wm_acc = 0; wm_out = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("win_aresetn", 32'(win_aresetn), 32'(m_flush_left == 0));
    chk("busy", 32'(busy), 32'(m_busy()));
    chk("done", 32'(done), 32'(m_done));
    chk("win_cntr", 32'(win_cntr), 32'(m_cntr));
    chk("win_cfg", 32'(win_cfg), 32'(m_cfg));
    chk("gate_tvalid", 32'(gate_tvalid), 32'(s_axis_tvalid & m_running));
    if (done === 1'b1) n_done_seen++;
    if (busy === 1'b1 && win_aresetn === 1'b1 && gate_tvalid === 1'b0) n_gap_cyc++;
    if (win_aresetn === 1'b0) n_rst_low++;
  endtask

  task automatic step(input bit st, input bit ab, input bit sv, input bit wr);
    bit gated, arst_n, prev_done, was_busy, wv;
    int lim;
    start = st; abort = ab; s_axis_tvalid = sv;
    wv = use_wm ? wm_out : wr;
    win_tvalid = wv;
    #1;
    chk("gate_comb", 32'(gate_tvalid), 32'(sv & m_running));
    gated  = sv & m_running;
    arst_n = (m_flush_left == 0);
    lim    = (m_cfg == 0) ? 1 : m_cfg;
    if (!arst_n) begin
      wm_acc = 0; wm_out = 0;
    end else begin
      wm_out = 0;
      if (gated) begin
        wm_acc++;
        if (wm_acc >= lim) begin wm_out = 1; wm_acc = 0; end
      end
    end
    prev_done = m_done;
    was_busy  = m_busy();
    m_done    = 0;
    if (!was_busy) begin
      if (!prev_done && st && !ab && cfg_count != '0) begin
        m_cfg = int'(cfg_len); m_count = int'(cfg_count); m_gap = int'(cfg_gap);
        m_cntr = 0; m_flush_left = FL; m_then_run = 1;
      end
    end else if (ab) begin
      m_flush_left = FL; m_then_run = 0; m_running = 0; m_gap_left = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0 && m_then_run) m_running = 1;
    end else if (m_running) begin
      if (wv) begin
        m_cntr++;
        if (m_cntr == m_count) begin m_running = 0; m_done = 1; end
        else if (m_gap != 0) begin m_running = 0; m_gap_left = m_gap; end
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
      if (m_gap_left == 0) m_running = 1;
    end
    @(posedge aclk);
    #1;
    check_outputs();
  endtask

  initial begin
    model_reset();
    use_wm = 1;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_win_aresetn", 32'(win_aresetn), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_win_cntr", 32'(win_cntr), 32'd0);
    chk("rst_win_cfg", 32'(win_cfg), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    step(0, 0, 0, 0);

    // len=4, count=3, gap=0, continuous valid
    cfg_len = 8'd4; cfg_count = CW'(3); cfg_gap = CW'(0);
    n_done_seen = 0;
    step(1, 0, 1, 0);
    repeat (30) step(0, 0, 1, 0);
    chk("t1_done_pulses", 32'(n_done_seen), 32'd1);
    chk("t1_win_cntr", 32'(win_cntr), 32'd3);

    // len=4, count=2, gap=5: dead time of exactly 5 cycles
    cfg_len = 8'd4; cfg_count = CW'(2); cfg_gap = CW'(5);
    n_gap_cyc = 0; n_done_seen = 0;
    step(1, 0, 1, 0);
    repeat (30) step(0, 0, 1, 0);
    chk("t2_gap_cycles", 32'(n_gap_cyc), 32'd5);
    chk("t2_done_pulses", 32'(n_done_seen), 32'd1);
    chk("t2_win_cntr", 32'(win_cntr), 32'd2);

    // count=0: start ignored
    cfg_count = CW'(0);
    n_rst_low = 0;
    step(1, 0, 1, 0);
    repeat (4) step(0, 0, 1, 0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_rst_low", 32'(n_rst_low), 32'd0);

    // abort in GAP after the first of three windows
    cfg_len = 8'd4; cfg_count = CW'(3); cfg_gap = CW'(6);
    step(1, 0, 1, 0);
    for (int i = 0; i < 40 && m_gap_left == 0; i++) step(0, 0, 1, 0);
    chk("t4_in_gap_busy", 32'(busy), 32'd1);
    chk("t4_in_gap_gate", 32'(gate_tvalid), 32'd0);
    n_rst_low = 0; n_done_seen = 0;
    step(0, 1, 1, 0);
    repeat (8) step(0, 0, 1, 0);
    chk("t4_rst_low", 32'(n_rst_low), 32'(FL));
    chk("t4_done_pulses", 32'(n_done_seen), 32'd0);
    chk("t4_win_cntr", 32'(win_cntr), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);

    // start+abort together in IDLE, then start while busy
    cfg_len = 8'd2; cfg_count = CW'(2); cfg_gap = CW'(0);
    step(1, 1, 1, 0);
    step(0, 0, 1, 0);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    n_done_seen = 0;
    step(1, 0, 1, 0);
    repeat (3) step(0, 0, 1, 0);
    cfg_len = 8'd7; cfg_count = CW'(9);
    step(1, 0, 1, 0);
    repeat (20) step(0, 0, 1, 0);
    chk("t5_win_cntr", 32'(win_cntr), 32'd2);
    chk("t5_win_cfg", 32'(win_cfg), 32'd2);
    chk("t5_done_pulses", 32'(n_done_seen), 32'd1);

    // aresetn asserted mid-RUN
    cfg_len = 8'd3; cfg_count = CW'(4); cfg_gap = CW'(1);
    step(1, 0, 1, 0);
    repeat (6) step(0, 0, 1, 0);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_win_aresetn", 32'(win_aresetn), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_win_cntr", 32'(win_cntr), 32'd0);
    chk("t6_win_cfg", 32'(win_cfg), 32'd0);
    chk("t6_gate", 32'(gate_tvalid), 32'd0);
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    cfg_len = 8'd1; cfg_count = CW'(2); cfg_gap = CW'(0);
    n_done_seen = 0;
    step(1, 0, 1, 0);
    repeat (15) step(0, 0, 1, 0);
    chk("t6_fresh_cntr", 32'(win_cntr), 32'd2);
    chk("t6_fresh_done", 32'(n_done_seen), 32'd1);

    // randomized runs: cfg is randomized every cycle and must only matter at start
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) use_wm = bit'($urandom_range(0, 1));
      cfg_len   = 8'($urandom_range(0, 3));
      cfg_count = CW'($urandom_range(0, 4));
      cfg_gap   = CW'($urandom_range(0, 3));
      step($urandom_range(0, 5) == 0, $urandom_range(0, 30) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
